// File: rtl/pb_pkg.sv
// Shared defaults and helpers for the pushbutton scanner with a key-code FIFO.
package pb_pkg;

  localparam int NUM_PB_DEF     = 21;
  localparam int TICK_DIV_DEF   = 10000;
  localparam int DB_SAMPLES_DEF = 4;
  localparam int FIFO_DEPTH_DEF = 8;

  // Key-code width; a single button still needs one bit.
  function automatic int code_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int CODE_W_DEF = code_w(NUM_PB_DEF);

  typedef logic [CODE_W_DEF-1:0] key_code_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO; a push into a full FIFO is accepted only
// when a pop frees a slot in the same cycle.
module sync_fifo
  import pb_pkg::*;
#(
  parameter int WIDTH = CODE_W_DEF,
  parameter int DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is never reset, so the head reads as zero while empty.
  assign dout = empty ? '0 : mem[rptr];

endmodule

// File: rtl/pb_scan_fifo.sv
// Debounces a bank of pushbuttons and queues the index of each newly
// pressed button into a FIFO, lowest index first when several rise together.
module pb_scan_fifo
  import pb_pkg::*;
#(
  parameter int  NUM_PB     = NUM_PB_DEF,
  parameter int  TICK_DIV   = TICK_DIV_DEF,
  parameter int  DB_SAMPLES = DB_SAMPLES_DEF,
  parameter int  FIFO_DEPTH = FIFO_DEPTH_DEF,
  localparam int CODE_W     = code_w(NUM_PB),
  localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              hwclk,
  input  logic              reset,
  input  logic [NUM_PB-1:0] pb,
  output logic [NUM_PB-1:0] pressed,
  output logic [CODE_W-1:0] key_code,
  output logic              key_valid,
  input  logic              key_ready,
  output logic [CNT_W-1:0]  key_count,
  output logic              overflow,
  input  logic              clr_ovf
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [NUM_PB-1:0]     sync_p0;
  logic [NUM_PB-1:0]     sync_p1;
  logic [PW-1:0]         presc;
  logic                  tick;
  logic [DB_SAMPLES-1:0] hist     [NUM_PB];
  logic [DB_SAMPLES-1:0] hist_nxt [NUM_PB];
  logic [NUM_PB-1:0]     pressed_last;
  logic [NUM_PB-1:0]     rise;
  logic [NUM_PB-1:0]     pending;
  logic [NUM_PB-1:0]     clr_mask;
  logic                  sel_vld;
  logic [CODE_W-1:0]     sel_idx;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  pop;
  logic                  drop;

  // Stage 0/1: two-flop synchronizer on the raw button levels.
  always_ff @(posedge hwclk) begin
    if (reset) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= pb;
      sync_p1 <= sync_p0;
    end
  end

  assign tick = (presc == PW'(TICK_DIV - 1));

  always_ff @(posedge hwclk) begin
    if (reset)     presc <= '0;
    else if (tick) presc <= '0;
    else           presc <= presc + PW'(1);
  end

  always_comb begin
    for (int i = 0; i < NUM_PB; i++) begin
      hist_nxt[i] = {hist[i][DB_SAMPLES-2:0], sync_p1[i]};
    end
  end

  // Debounce stage: level only changes on a full run of equal samples.
  always_ff @(posedge hwclk) begin
    if (reset) begin
      for (int i = 0; i < NUM_PB; i++) hist[i] <= '0;
      pressed <= '0;
    end else if (tick) begin
      for (int i = 0; i < NUM_PB; i++) begin
        hist[i] <= hist_nxt[i];
        if (&hist_nxt[i])       pressed[i] <= 1'b1;
        else if (~|hist_nxt[i]) pressed[i] <= 1'b0;
      end
    end
  end

  assign rise = pressed & ~pressed_last;

  always_comb begin
    sel_vld  = 1'b0;
    sel_idx  = '0;
    clr_mask = '0;
    for (int i = 0; i < NUM_PB; i++) begin
      if (pending[i] && !sel_vld) begin
        sel_vld     = 1'b1;
        sel_idx     = CODE_W'(i);
        clr_mask[i] = 1'b1;
      end
    end
  end

  // Pending stage: a new rise re-arms a bit even as it is being served.
  always_ff @(posedge hwclk) begin
    if (reset) begin
      pressed_last <= '0;
      pending      <= '0;
    end else begin
      pressed_last <= pressed;
      pending      <= (pending & ~clr_mask) | rise;
    end
  end

  assign key_valid = ~fifo_empty;
  assign pop       = key_ready & key_valid;
  assign drop      = sel_vld & fifo_full & ~pop;

  always_ff @(posedge hwclk) begin
    if (reset)        overflow <= 1'b0;
    else if (drop)    overflow <= 1'b1;
    else if (clr_ovf) overflow <= 1'b0;
  end

  sync_fifo #(
    .WIDTH (CODE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (hwclk),
    .rst   (reset),
    .push  (sel_vld),
    .pop   (pop),
    .din   (sel_idx),
    .dout  (key_code),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (key_count)
  );

endmodule

// File: tb/tb_pb_scan_fifo.sv
// Bench for pb_scan_fifo: directed scenarios plus random button activity,
// every cycle compared against a queue-based behavioural model.
module tb_pb_scan_fifo;

  localparam int NUM_PB     = 21;
  localparam int TICK_DIV   = 4;
  localparam int DB_SAMPLES = 3;
  localparam int FIFO_DEPTH = 4;

  logic              hwclk     = 1'b0;
  logic              reset     = 1'b1;
  logic [NUM_PB-1:0] pb        = '0;
  logic              key_ready = 1'b0;
  logic              clr_ovf   = 1'b0;
  logic [NUM_PB-1:0] pressed;
  logic [4:0]        key_code;
  logic              key_valid;
  logic [2:0]        key_count;
  logic              overflow;

  int total = 0;
  int bad   = 0;

  pb_scan_fifo #(
    .NUM_PB     (NUM_PB),
    .TICK_DIV   (TICK_DIV),
    .DB_SAMPLES (DB_SAMPLES),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .hwclk     (hwclk),
    .reset     (reset),
    .pb        (pb),
    .pressed   (pressed),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .key_count (key_count),
    .overflow  (overflow),
    .clr_ovf   (clr_ovf)
  );

  always #5 hwclk = ~hwclk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: run-length debounce, event-based press detection,
  // a queue for the FIFO.
  logic [NUM_PB-1:0] m_pressed = '0;
  logic [NUM_PB-1:0] m_pend    = '0;
  logic [NUM_PB-1:0] m_rose    = '0;
  logic [NUM_PB-1:0] m_pbd1    = '0;
  logic [NUM_PB-1:0] m_pbd2    = '0;
  int                m_run [NUM_PB];
  bit                m_val [NUM_PB];
  int                m_q [$];
  bit                m_ovf = 1'b0;
  int                m_cyc = 0;

  task automatic model_step();
    int                idx;
    bit                found;
    bit                drop;
    logic [NUM_PB-1:0] nxt;
    logic [NUM_PB-1:0] npend;
    if (reset) begin
      m_pressed = '0;
      m_pend    = '0;
      m_rose    = '0;
      m_pbd1    = '0;
      m_pbd2    = '0;
      for (int i = 0; i < NUM_PB; i++) begin
        m_run[i] = DB_SAMPLES;
        m_val[i] = 1'b0;
      end
      m_q.delete();
      m_ovf = 1'b0;
      m_cyc = 0;
      return;
    end
    if (key_ready && m_q.size() > 0) void'(m_q.pop_front());
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < NUM_PB; i++) begin
      if (m_pend[i] && !found) begin
        found = 1'b1;
        idx   = i;
      end
    end
    npend = m_pend;
    drop  = 1'b0;
    if (found) begin
      npend[idx] = 1'b0;
      if (m_q.size() < FIFO_DEPTH) m_q.push_back(idx);
      else drop = 1'b1;
    end
    if (drop) m_ovf = 1'b1;
    else if (clr_ovf) m_ovf = 1'b0;
    nxt = m_pressed;
    if (m_cyc % TICK_DIV == TICK_DIV - 1) begin
      for (int i = 0; i < NUM_PB; i++) begin
        if (m_pbd2[i] == m_val[i]) begin
          if (m_run[i] < DB_SAMPLES) m_run[i]++;
        end else begin
          m_val[i] = m_pbd2[i];
          m_run[i] = 1;
        end
        if (m_run[i] >= DB_SAMPLES) nxt[i] = m_val[i];
      end
    end
    npend     = npend | m_rose;
    m_rose    = nxt & ~m_pressed;
    m_pressed = nxt;
    m_pend    = npend;
    m_pbd2    = m_pbd1;
    m_pbd1    = pb;
    m_cyc++;
  endtask

  always @(posedge hwclk) begin
    model_step();
    #1;
    check("pressed",   pressed,   m_pressed);
    check("key_valid", key_valid, m_q.size() > 0);
    check("key_code",  key_code,  (m_q.size() > 0) ? m_q[0] : 0);
    check("key_count", key_count, m_q.size());
    check("overflow",  overflow,  m_ovf);
  end

  task automatic drain();
    pb        = '0;
    key_ready = 1'b1;
    repeat (40) @(negedge hwclk);
    key_ready = 1'b0;
  endtask

  initial begin
    int n;
    int btn [5];
    int b6;
    int r;
    bit dup;
    int exp_order [3];
    exp_order = '{3, 7, 12};

    reset = 1'b1;
    repeat (3) @(negedge hwclk);
    check("rst_valid",   key_valid, 0);
    check("rst_count",   key_count, 0);
    check("rst_pressed", pressed,   0);
    check("rst_ovf",     overflow,  0);
    check("rst_code",    key_code,  0);
    reset = 1'b0;

    // Clean press of button 5.
    pb[5] = 1'b1;
    n = 0;
    while (!pressed[5] && n < 100) begin @(negedge hwclk); n++; end
    check("p5_seen", n < 100, 1);
    n = 0;
    while (!key_valid && n < 10) begin @(negedge hwclk); n++; end
    check("p5_latency", n, 2);
    check("p5_code",    key_code, 5);
    check("p5_count",   key_count, 1);
    drain();

    // Bounce on button 2, then settle low.
    for (int k = 0; k < 8; k++) begin
      pb[2] = ~pb[2];
      repeat (5) @(negedge hwclk);
    end
    pb[2] = 1'b0;
    repeat (30) @(negedge hwclk);
    check("bounce_pressed", pressed[2], 0);
    check("bounce_count",   key_count,  0);

    // Simultaneous press of 7, 3, 12.
    pb[7]  = 1'b1;
    pb[3]  = 1'b1;
    pb[12] = 1'b1;
    n = 0;
    while (key_count != 3 && n < 100) begin @(negedge hwclk); n++; end
    check("sim_count", key_count, 3);
    for (int k = 0; k < 3; k++) begin
      check("sim_order", key_code, exp_order[k]);
      key_ready = 1'b1;
      @(negedge hwclk);
      key_ready = 1'b0;
    end
    check("sim_empty", key_valid, 0);
    drain();

    // Overflow: five distinct presses into a four-entry FIFO.
    for (int k = 0; k < 5; k++) begin
      do begin
        btn[k] = $urandom_range(0, NUM_PB - 1);
        dup = 1'b0;
        for (int j = 0; j < k; j++) if (btn[j] == btn[k]) dup = 1'b1;
      end while (dup);
      pb[btn[k]] = 1'b1;
      repeat (24) @(negedge hwclk);
    end
    check("ovf_count", key_count, 4);
    check("ovf_flag",  overflow,  1);
    check("ovf_head",  key_code,  btn[0]);
    pb = '0;
    repeat (24) @(negedge hwclk);
    clr_ovf = 1'b1;
    @(negedge hwclk);
    clr_ovf = 1'b0;
    check("ovf_clear", overflow, 0);

    // Full FIFO with a pop in the very cycle of a new push.
    b6 = $urandom_range(0, NUM_PB - 1);
    pb[b6] = 1'b1;
    n = 0;
    while (m_pend == '0 && n < 100) begin @(negedge hwclk); n++; end
    check("fp_pending", n < 100, 1);
    key_ready = 1'b1;
    @(negedge hwclk);
    key_ready = 1'b0;
    check("fp_count", key_count, 4);
    check("fp_ovf",   overflow,  0);
    drain();

    // Random button activity, consumer stalls and overflow clears.
    for (int k = 0; k < 500; k++) begin
      if ($urandom_range(0, 5) == 0) begin
        r = $urandom_range(0, NUM_PB - 1);
        pb[r] = ~pb[r];
      end
      key_ready = ($urandom_range(0, 3) == 0);
      clr_ovf   = ($urandom_range(0, 19) == 0);
      @(negedge hwclk);
    end
    clr_ovf = 1'b0;
    drain();

    // Reset in the middle of a queued stream.
    pb[1]  = 1'b1;
    pb[9]  = 1'b1;
    pb[17] = 1'b1;
    n = 0;
    while (key_count != 3 && n < 100) begin @(negedge hwclk); n++; end
    check("mid_count", key_count, 3);
    reset = 1'b1;
    @(negedge hwclk);
    reset = 1'b0;
    check("mid_valid",   key_valid, 0);
    check("mid_count0",  key_count, 0);
    check("mid_pressed", pressed,   0);
    check("mid_ovf",     overflow,  0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
